// File: rtl/dmem_bank.sv
// dmem_bank: synchronous byte-lane data memory with valid/ready requests,
// pipelined read response, post-reset hardware clear and out-of-range
// address detection.
// Optional build macro: DMEM_BANK_PARITY_EN adds one even-parity bit per
// byte, checked on every read and reported through rsp_err_o.

// One byte lane of the storage array: single shared address, write and
// synchronous read. Parity (when enabled) lives alongside the byte.
module dmem_bank_lane #(
    parameter int DEPTH = 1024,
    parameter int IW    = 10
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [IW-1:0] addr_i,
    input  logic [7:0]    wdata_i,
    output logic [7:0]    rdata_o,
    output logic          perr_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    // Byte storage: write on we_i, registered read on re_i
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

`ifdef DMEM_BANK_PARITY_EN
    logic par_q [DEPTH];
    logic rpar_q;

    // Even parity stored per byte; a cleared byte (0x00) stores parity 0
    always_ff @(posedge clk_i) begin
        if (we_i) par_q[addr_i] <= ^wdata_i;
        if (re_i) rpar_q <= par_q[addr_i];
    end

    assign perr_o = (^rdata_q) ^ rpar_q;
`else
    assign perr_o = 1'b0;
`endif

endmodule

module dmem_bank #(
    parameter int DWIDTH     = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 1024,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DWIDTH-1:0]     req_wdata_i,
    input  logic [DWIDTH/8-1:0]   req_be_i,
    output logic                  rsp_valid_o,
    output logic [DWIDTH-1:0]     rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  wr_err_o,
    output logic                  init_done_o
);

    localparam int NUM_LANES = DWIDTH / 8;
    localparam int IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Full-width compare: one extra bit so DEPTH == 2**ADDR_WIDTH fits
    localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [IW-1:0]       CLR_LAST = IW'(DEPTH - 1);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_e;

    state_e                state_q;
    logic [IW-1:0]         clr_cnt_q;
    logic                  req_ready_q;
    logic                  init_done_q;
    logic                  wr_err_q;
    logic                  wr_err_d;
    logic                  rd_oor_q;
    logic [RD_LATENCY:1]   vld_pipe_q;

    logic                  in_range;
    logic                  acc;
    logic                  acc_wr;
    logic                  acc_rd;
    logic                  clr_we;
    logic [IW-1:0]         lane_addr;
    logic [DWIDTH-1:0]     rd_word;
    logic [NUM_LANES-1:0]  perr_vec;
    logic [DWIDTH:0]       stage1;
    logic [DWIDTH:0]       stage_last;

    // Request decode; clear and requests never overlap since ready is low in CLEAR
    assign in_range  = ({1'b0, req_addr_i} < DEPTH_W);
    assign acc       = req_valid_i & req_ready_q;
    assign acc_wr    = acc & req_we_i;
    assign acc_rd    = acc & ~req_we_i;
    assign clr_we    = (state_q == S_CLEAR);
    assign lane_addr = clr_we ? clr_cnt_q : req_addr_i[IW-1:0];

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            logic       lane_we;
            logic [7:0] lane_wdata;

            assign lane_we    = clr_we | (acc_wr & in_range & req_be_i[g]);
            assign lane_wdata = clr_we ? 8'h00 : req_wdata_i[8*g +: 8];

            dmem_bank_lane #(
                .DEPTH (DEPTH),
                .IW    (IW)
            ) u_lane (
                .clk_i   (clk_i),
                .we_i    (lane_we),
                .re_i    (acc_rd & in_range),
                .addr_i  (lane_addr),
                .wdata_i (lane_wdata),
                .rdata_o (rd_word[8*g +: 8]),
                .perr_o  (perr_vec[g])
            );
        end
    endgenerate

    // Clear sequencer: zero every word once, then open the request port for good
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_CLEAR;
            clr_cnt_q   <= '0;
            req_ready_q <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == CLR_LAST) begin
                        state_q     <= S_RUN;
                        req_ready_q <= 1'b1;
                        init_done_q <= 1'b1;
                    end
                end
                default: begin
                    req_ready_q <= 1'b1;
                    init_done_q <= 1'b1;
                end
            endcase
        end
    end

    assign wr_err_d = acc_wr & ~in_range;

    // Out-of-range write flag, one-cycle pulse after acceptance
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) wr_err_q <= 1'b0;
        else          wr_err_q <= wr_err_d;
    end

    // Read-valid shift register; reset drops any read still in flight
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_pipe_q <= '0;
        end else begin
            vld_pipe_q[1] <= acc_rd;
            for (int k = 2; k <= RD_LATENCY; k++) vld_pipe_q[k] <= vld_pipe_q[k-1];
        end
    end

    // Remember whether the read in the array register was out of range
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)    rd_oor_q <= 1'b0;
        else if (acc_rd) rd_oor_q <= ~in_range;
    end

    // First response stage: {err, data}; out-of-range reads return zero
    assign stage1 = {rd_oor_q | (|perr_vec), rd_oor_q ? {DWIDTH{1'b0}} : rd_word};

    generate
        if (RD_LATENCY == 1) begin : g_lat1
            assign stage_last = stage1;
        end else begin : g_pipe
            logic [DWIDTH:0] pipe_q [RD_LATENCY-1];

            // Data/err delay line, qualified by vld_pipe_q at the output
            always_ff @(posedge clk_i) begin
                pipe_q[0] <= stage1;
                for (int k = 1; k < RD_LATENCY - 1; k++) pipe_q[k] <= pipe_q[k-1];
            end

            assign stage_last = pipe_q[RD_LATENCY-2];
        end
    endgenerate

    assign req_ready_o = req_ready_q;
    assign init_done_o = init_done_q;
    assign wr_err_o    = wr_err_q;
    assign rsp_valid_o = vld_pipe_q[RD_LATENCY];
    assign rsp_rdata_o = vld_pipe_q[RD_LATENCY] ? stage_last[DWIDTH-1:0] : {DWIDTH{1'b0}};
    assign rsp_err_o   = vld_pipe_q[RD_LATENCY] & stage_last[DWIDTH];

endmodule

// File: doc/dmem_bank.md
Name: dmem_bank

Overview:
- Parametrised, synchronous data memory for the processor datapath.
- Successor to the single-port, combinational-read data RAM.
- Adds byte-enable writes, a valid/ready request interface and a pipelined read response with configurable latency.
- Adds a hardware clear sequence after reset and out-of-range address detection.
- Sits between the core load/store unit and the storage array; one request per cycle when ready.

Parameters:
- DWIDTH, 16, data word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 16, word address width.
- DEPTH, 1024, number of words implemented; must satisfy DEPTH <= 2^ADDR_WIDTH.
- RD_LATENCY, 2, cycles from accepted read to rsp_valid; legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DWIDTH  write data.
- req_be  in  DWIDTH/8  byte enables; bit i covers bits [8i+7:8i].
- rsp_valid  out  1  read data valid, one-cycle pulse per accepted read.
- rsp_rdata  out  DWIDTH  read data; 0 whenever rsp_valid = 0.
- rsp_err  out  1  accompanies rsp_valid; address was out of range.
- wr_err  out  1  one-cycle pulse, one cycle after an out-of-range write is accepted.
- init_done  out  1  clear sequence complete.

Behaviour:
- Reset (rst_n low, asynchronous) drives:
  - req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, wr_err = 0, init_done = 0.
  - Read pipeline flushed; clear counter = 0; FSM = CLEAR.
  - Array contents are not reset directly.
- FSM states:
  - CLEAR: writes 0 to address clr_cnt each cycle, clr_cnt++.
    - The last write lands at DEPTH-1; transition to RUN on the next edge, after exactly DEPTH cycles in CLEAR.
    - req_ready = 0 throughout CLEAR.
  - RUN: req_ready = 1 and init_done = 1 permanently until the next reset.
- Accept: a request is accepted when req_valid && req_ready on a rising edge.
- Write: for each i with req_be[i] = 1, mem[addr] byte i <= req_wdata byte i; other bytes are unchanged.
  - req_be = 0 is a legal no-op.
  - No response is generated.
- Read:
  - Array is read synchronously at acceptance.
  - Data travels through an (RD_LATENCY-1)-deep register pipeline.
  - rsp_valid rises exactly RD_LATENCY cycles after the accepting edge.
  - Back-to-back reads give back-to-back responses, in order.
  - There is no response back-pressure.
- Ordering:
  - A read accepted in the cycle after a write to the same address returns the new data.
  - Read and write cannot share a cycle; the single request port prevents it.
- Out of range (addr >= DEPTH):
  - Write: dropped, no array change; wr_err pulses one cycle after acceptance.
  - Read: rsp_rdata = 0, rsp_err = 1 with its rsp_valid.
- Address decode uses the full ADDR_WIDTH compare against DEPTH; no wrap or aliasing.
- Reset mid-CLEAR: clear restarts from address 0.
- Reset with reads in flight: those reads are discarded, no rsp_valid.

Optional Feature:
- Macro: DMEM_BANK_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte, computed on write.
  - The CLEAR sequence writes parity 0.
  - On read, parity is rechecked; mismatch on any byte asserts rsp_err with rsp_valid. Data is still returned.
  - A write with partial req_be updates only the parity of the written bytes.
- Undefined: no parity storage; rsp_err reflects the out-of-range condition only.

Test Plan:
- Reset, then hold req_valid = 1:
  - req_ready stays 0 for exactly DEPTH cycles after rst_n rises, then goes to 1 with init_done = 1.
  - A read of addr 5 then returns 0x0000.
- Write addr 3 = 0xBEEF with be = 2'b11, then read addr 3 on the next cycle:
  - rsp_valid high exactly RD_LATENCY (2) cycles after the read, rsp_rdata = 0xBEEF.
- Write addr 3 = 0x1234 with be = 2'b01 over 0xBEEF, then read:
  - rsp_rdata = 0xBE34.
- Back-to-back reads of addrs 0, 1, 2 over 3 consecutive cycles, after preloading 0x0A, 0x0B, 0x0C:
  - 3 consecutive rsp_valid pulses carrying 0x000A, 0x000B, 0x000C.
- With DEPTH = 1024, write addr 1024 = 0xFFFF, then read addr 1024 and addr 0:
  - wr_err pulses one cycle after the write; addr 0 is unchanged.
  - The addr 1024 response is rsp_rdata = 0, rsp_err = 1.
- Interrupt a clear or read:
  - Assert rst_n low at CLEAR cycle 100: after release, req_ready returns only after DEPTH further cycles.
  - Reset one cycle after an accepted read: no rsp_valid appears.
